fake_jpeg_1106_stim_gen: RTL and testbench

Upstream stimulus stage for the `fake_jpeg_1106_n_197` netlist. It generates a programmable-length stream of 49-bit pseudo-random input vectors from a maximal-length LFSR. The stream is presented under a valid/ready handshake, with bit i driving netlist input n_i. The downstream capture logic samples n_197 when `vec_valid && vec_ready`.

---
 rtl/fake_jpeg_1106_stim_gen_if.sv | 15 +
 rtl/fake_jpeg_1106_stim_gen.sv | 107 ++++++++++
 tb/tb_fake_jpeg_1106_stim_gen.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/fake_jpeg_1106_stim_gen_if.sv
// Vector stream bus between the stimulus generator and the netlist capture stage.
//   vec_out   : 49-bit input vector, bit i drives netlist input n_i
//   vec_valid : vec_out holds an unconsumed vector
//   vec_ready : consumer accepts vec_out this cycle
// master = generator side, slave = capture side.
interface fake_jpeg_1106_stim_gen_if #(
  parameter int WIDTH = 49
) ();
  logic [WIDTH-1:0] vec_out;
  logic             vec_valid;
  logic             vec_ready;

  modport master (output vec_out, output vec_valid, input vec_ready);
  modport slave  (input vec_out, input vec_valid, output vec_ready);
endinterface

// File: rtl/fake_jpeg_1106_stim_gen.sv
// Upstream stimulus stage for the fake_jpeg_1106_n_197 netlist: emits a
// programmable number of pseudo-random vectors from a 49-bit maximal-length
// Fibonacci LFSR (x^49 + x^40 + 1) under a valid/ready handshake.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   seed_load   : load seed_in into the LFSR (IDLE/DONE only; zero loads 1)
//   seed_in     : seed value
//   num_vec     : vectors per run, captured on an accepted start
//   start       : begin a run (IDLE/DONE only)
//   abort       : end a run early (RUN only), keeps vec_cnt and the LFSR
//   vec         : vector stream (vec_out / vec_valid / vec_ready)
//   vec_cnt     : vectors accepted in the current/last run
//   busy, done  : high in RUN / DONE respectively
// All outputs are registered; vec_out is the LFSR register itself.
module fake_jpeg_1106_stim_gen #(
  parameter int                 WIDTH = 49,
  parameter int                 CNT_W = 16,
  parameter logic [WIDTH-1:0]   SEED  = 49'h1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      seed_load,
  input  logic [WIDTH-1:0]          seed_in,
  input  logic [CNT_W-1:0]          num_vec,
  input  logic                      start,
  input  logic                      abort,
  fake_jpeg_1106_stim_gen_if.master vec,
  output logic [CNT_W-1:0]          vec_cnt,
  output logic                      busy,
  output logic                      done
);

  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  // A zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? ONE : SEED;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] lfsr;
  logic [CNT_W-1:0] target;
  logic             valid_q;
  logic             hs;
  logic [WIDTH-1:0] lfsr_nxt;

  assign lfsr_nxt      = {lfsr[WIDTH-2:0], lfsr[48] ^ lfsr[39]};
  assign hs            = valid_q && vec.vec_ready;
  assign vec.vec_out   = lfsr;
  assign vec.vec_valid = valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      lfsr    <= SEED_EFF;
      target  <= '0;
      vec_cnt <= '0;
      valid_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // A seed loaded together with start becomes the run's first vector.
          if (seed_load)
            lfsr <= (seed_in == '0) ? ONE : seed_in;
          if (start) begin
            vec_cnt <= '0;
            target  <= num_vec;
            if (num_vec != '0) begin
              state   <= RUN;
              valid_q <= 1'b1;
              busy    <= 1'b1;
              done    <= 1'b0;
            end else begin
              state   <= DONE;
              done    <= 1'b1;
            end
          end
        end
        RUN: begin
          if (hs) begin
            vec_cnt <= vec_cnt + 1'b1;
            lfsr    <= lfsr_nxt;
          end
          // Abort wins over run completion; a same-cycle handshake still counts.
          if (abort) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            busy    <= 1'b0;
          end else if (hs && (vec_cnt == target - 1'b1)) begin
            state   <= DONE;
            valid_q <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fake_jpeg_1106_stim_gen.sv
module tb_fake_jpeg_1106_stim_gen;
  localparam int W = 49;
  localparam int C = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          seed_load = 1'b0;
  logic [W-1:0]  seed_in = '0;
  logic [C-1:0]  num_vec = '0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [C-1:0]  vec_cnt;
  logic          busy, done;

  int n_assert = 0;
  int n_fail   = 0;

  fake_jpeg_1106_stim_gen_if #(.WIDTH(W)) vif ();

  fake_jpeg_1106_stim_gen #(.WIDTH(W), .CNT_W(C), .SEED(49'h1)) dut (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed_in(seed_in),
    .num_vec(num_vec), .start(start), .abort(abort), .vec(vif.master),
    .vec_cnt(vec_cnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Next LFSR state as polynomial arithmetic: multiply by x modulo the
  // 49-bit width, feeding back the x^49 and x^40 terms into bit 0.
  function automatic logic [63:0] model_next(logic [63:0] v);
    logic [63:0] mask;
    logic [63:0] fb;
    mask = (64'd1 << W) - 64'd1;
    fb   = ((v >> 48) ^ (v >> 39)) & 64'd1;
    return ((v << 1) & mask) | fb;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] mvec;   // model of the vector currently presented
  int          mcnt;
  logic        rdy;
  logic [63:0] saved;

  initial begin
    vif.vec_ready = 1'b0;
    mvec = 64'h1;
    #12 rst = 1'b0;
    #1;
    // Reset state
    chk("rst_vec",   vif.vec_out, 64'h1);
    chk("rst_valid", vif.vec_valid, 0);
    chk("rst_cnt",   vec_cnt, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);

    // Tap check: 3 vectors from seed 1
    @(negedge clk);
    num_vec = 3; start = 1; vif.vec_ready = 1;
    tick(); start = 0;
    chk("t1_valid", vif.vec_valid, 1);
    chk("t1_busy",  busy, 1);
    chk("t1_v0",    vif.vec_out, 64'h1);
    tick(); chk("t1_v1", vif.vec_out, 64'h2);
    tick(); chk("t1_v2", vif.vec_out, 64'h4);
    tick();
    chk("t1_done",  done, 1);
    chk("t1_cnt",   vec_cnt, 3);
    chk("t1_valid_lo", vif.vec_valid, 0);

    // Tap feedback with seed_load + start together
    seed_load = 1; seed_in = 49'h80_0000_0000; start = 1; num_vec = 2;
    tick(); seed_load = 0; start = 0;
    chk("t2_done_clr", done, 0);
    chk("t2_v0", vif.vec_out, 64'h80_0000_0000);
    tick(); chk("t2_v1", vif.vec_out, 64'h100_0000_0001);
    tick(); chk("t2_done", done, 1);
    mvec = model_next(64'h100_0000_0001);
    chk("t2_next", vif.vec_out, mvec);

    // Backpressure
    vif.vec_ready = 0; num_vec = 2; start = 1;
    tick(); start = 0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_vec",   vif.vec_out, mvec);
      chk("bp_cnt",   vec_cnt, 0);
      chk("bp_valid", vif.vec_valid, 1);
      tick();
    end
    vif.vec_ready = 1;
    tick(); mvec = model_next(mvec);
    chk("bp_cnt1", vec_cnt, 1);
    chk("bp_vec1", vif.vec_out, mvec);
    chk("bp_nodone", done, 0);
    tick(); mvec = model_next(mvec);
    chk("bp_cnt2", vec_cnt, 2);
    chk("bp_done", done, 1);

    // Zero seed loads 1; zero-length run
    seed_load = 1; seed_in = '0;
    tick(); seed_load = 0; mvec = 64'h1;
    chk("z_seed", vif.vec_out, 64'h1);
    num_vec = 0; start = 1;
    tick(); start = 0;
    chk("z_done",  done, 1);
    chk("z_valid", vif.vec_valid, 0);
    chk("z_cnt",   vec_cnt, 0);
    tick(); chk("z_valid2", vif.vec_valid, 0);

    // Abort after 5 of 10 accepted
    num_vec = 10; start = 1; vif.vec_ready = 1;
    tick(); start = 0;
    for (int i = 0; i < 5; i++) begin tick(); mvec = model_next(mvec); end
    chk("ab_cnt5", vec_cnt, 5);
    vif.vec_ready = 0; abort = 1;
    tick(); abort = 0;
    chk("ab_busy",  busy, 0);
    chk("ab_valid", vif.vec_valid, 0);
    chk("ab_cnt",   vec_cnt, 5);
    chk("ab_done",  done, 0);
    chk("ab_vec",   vif.vec_out, mvec);
    chk("ab_vec20", vif.vec_out, 64'h20);
    num_vec = 1; start = 1; vif.vec_ready = 1;
    tick(); start = 0;
    chk("ab_restart", vif.vec_out, 64'h20);
    tick(); mvec = model_next(mvec);
    chk("ab_rdone", done, 1);

    // Abort together with a handshake: it still counts
    num_vec = 4; start = 1;
    tick(); start = 0;
    abort = 1;
    tick(); abort = 0; mvec = model_next(mvec);
    chk("abh_cnt",  vec_cnt, 1);
    chk("abh_vec",  vif.vec_out, mvec);
    chk("abh_busy", busy, 0);
    chk("abh_done", done, 0);

    // Randomized runs against the model
    for (int r = 0; r < 20; r++) begin
      int n;
      int budget;
      n = $urandom_range(0, 12);
      if ($urandom_range(0, 3) == 0) begin
        saved = {15'd0, $urandom_range(0, 1) == 0 ? 17'd0 : 17'($urandom), $urandom};
        seed_load = 1; seed_in = saved[W-1:0];
        mvec = (saved == 0) ? 64'h1 : saved;
      end
      num_vec = C'(n); start = 1;
      tick(); start = 0; seed_load = 0;
      mcnt = 0;
      chk("rnd_cnt0", vec_cnt, 0);
      chk("rnd_vec0", vif.vec_out, mvec);
      if (n == 0) begin
        chk("rnd_zdone", done, 1);
        chk("rnd_zvalid", vif.vec_valid, 0);
      end else begin
        budget = 0;
        while (mcnt < n && budget < 200) begin
          rdy = 1'($urandom_range(0, 1));
          vif.vec_ready = rdy;
          tick();
          budget++;
          if (rdy) begin mvec = model_next(mvec); mcnt++; end
          chk("rnd_vec", vif.vec_out, mvec);
          chk("rnd_cnt", vec_cnt, mcnt);
          chk("rnd_valid", vif.vec_valid, (mcnt < n) ? 1 : 0);
        end
        chk("rnd_budget", (budget < 200) ? 1 : 0, 1);
        chk("rnd_done", done, 1);
        chk("rnd_busy", busy, 0);
      end
    end

    // Async reset mid-run
    vif.vec_ready = 1; num_vec = 8; start = 1;
    tick(); start = 0;
    tick();
    #2 rst = 1;
    #1;
    chk("ar_vec",   vif.vec_out, 64'h1);
    chk("ar_valid", vif.vec_valid, 0);
    chk("ar_cnt",   vec_cnt, 0);
    chk("ar_busy",  busy, 0);
    chk("ar_done",  done, 0);
    @(negedge clk); rst = 0;
    tick();
    chk("ar_idle", vif.vec_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
